// File: rtl/game_stage_controller_pkg.sv
// Shared types and default timing for the game stage controller.
package game_stage_controller_pkg;

    typedef logic [2:0] game_stage_t;

    typedef enum logic [2:0] {
        IDLE,
        INTRO,
        PLAYING,
        PLAYER_HIT,
        CLEAR,
        OVER,
        WON
    } state_t;

    // Four BCD digits, index 3 is the most significant.
    typedef logic [3:0][3:0] bcd_score_t;

    localparam int DEF_INTRO_FRAMES   = 120;
    localparam int DEF_CLEAR_FRAMES   = 90;
    localparam int DEF_RESPAWN_FRAMES = 60;
    localparam int DEF_INITIAL_LIVES  = 3;
    localparam int DEF_LAST_STAGE     = 4;
    localparam int DEF_BOSS_STAGE     = 3;

    localparam bcd_score_t SCORE_MAX = 16'h9999;

endpackage

// File: rtl/game_stage_controller_bcd_score_adder.sv
// Combinational BCD adder: adds an 8-bit binary increment to a 4-digit score,
// saturating at 9999.
module bcd_score_adder
    import game_stage_controller_pkg::*;
(
    input  bcd_score_t score_in,
    input  logic [7:0] increment,
    output bcd_score_t score_out
);

    bcd_score_t inc_digits;
    bcd_score_t sum_digits;
    logic       carry;
    logic [4:0] digit_sum;

    always_comb begin
        inc_digits    = '0;
        inc_digits[0] = 4'(increment % 8'd10);
        inc_digits[1] = 4'((increment / 8'd10) % 8'd10);
        inc_digits[2] = 4'(increment / 8'd100);
        sum_digits    = '0;
        carry         = 1'b0;
        digit_sum     = '0;
        for (int i = 0; i < 4; i++) begin
            digit_sum = {1'b0, score_in[i]} + {1'b0, inc_digits[i]} + {4'b0, carry};
            if (digit_sum > 5'd9) begin
                sum_digits[i] = 4'(digit_sum - 5'd10);
                carry         = 1'b1;
            end else begin
                sum_digits[i] = digit_sum[3:0];
                carry         = 1'b0;
            end
        end
        // A carry out of the top digit means the true total exceeds 9999.
        score_out = carry ? SCORE_MAX : sum_digits;
    end

endmodule

// File: rtl/game_stage_controller.sv
// Game-flow controller: stage sequencing, lives and BCD score for the HUD.
// Define GAME_STAGE_BONUS_EN to award a 10 x lives clear bonus and expose bonus_pulse.
module game_stage_controller
    import game_stage_controller_pkg::*;
#(
    parameter int INTRO_FRAMES   = DEF_INTRO_FRAMES,
    parameter int CLEAR_FRAMES   = DEF_CLEAR_FRAMES,
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
    parameter int INITIAL_LIVES  = DEF_INITIAL_LIVES,
    parameter int LAST_STAGE     = DEF_LAST_STAGE,
    parameter int BOSS_STAGE     = DEF_BOSS_STAGE
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        start_pulse,
    input  logic        all_monsters_dead,
    input  logic        monster_died_pulse,
    input  logic        boss_dead,
    input  logic        player_died_pulse,
    output game_stage_t stage_num,
    output logic        stage_enable,
    output logic        stage_resetN,
    output logic        show_banner,
    output logic [2:0]  lives,
    output logic [15:0] score,
    output logic        game_over,
`ifdef GAME_STAGE_BONUS_EN
    output logic        game_won,
    output logic        bonus_pulse
`else
    output logic        game_won
`endif
);

    state_t      state_q, state_d;
    game_stage_t stage_num_q, stage_num_d;
    logic [2:0]  lives_q, lives_d;
    bcd_score_t  score_q, score_d, score_sum;
    logic [15:0] timer_q, timer_d;
    logic        stage_enable_q, stage_enable_d;
    logic        stage_resetN_q, stage_resetN_d;
    logic        show_banner_q, show_banner_d;
    logic        game_over_q, game_over_d;
    logic        game_won_q, game_won_d;
    logic        stage_done;
    logic        clear_now;
    logic [7:0]  score_inc;

    assign stage_done = (stage_num_q == game_stage_t'(BOSS_STAGE)) ? boss_dead : all_monsters_dead;
    assign clear_now  = (state_q == PLAYING) && stage_done;

`ifdef GAME_STAGE_BONUS_EN
    logic bonus_pulse_q;
    assign score_inc = {7'd0, monster_died_pulse} + (clear_now ? {5'd0, lives_q} * 8'd10 : 8'd0);
`else
    assign score_inc = {7'd0, monster_died_pulse};
`endif

    bcd_score_adder u_score_adder (
        .score_in  (score_q),
        .increment (score_inc),
        .score_out (score_sum)
    );

    always_comb begin
        state_d        = state_q;
        stage_num_d    = stage_num_q;
        lives_d        = lives_q;
        score_d        = score_q;
        timer_d        = timer_q;
        stage_resetN_d = 1'b1;
        unique case (state_q)
            IDLE, OVER, WON: begin
                if (start_pulse) begin
                    state_d        = INTRO;
                    stage_num_d    = 3'd1;
                    lives_d        = 3'(INITIAL_LIVES);
                    score_d        = '0;
                    timer_d        = '0;
                    stage_resetN_d = 1'b0;
                end
            end
            INTRO: begin
                if (startOfFrame) begin
                    if (timer_q == 16'(INTRO_FRAMES - 1)) state_d = PLAYING;
                    else timer_d = timer_q + 16'd1;
                end
            end
            PLAYING: begin
                score_d = score_sum;
                if (stage_done) begin
                    state_d = CLEAR;
                    timer_d = '0;
                end else if (player_died_pulse) begin
                    if (lives_q > 3'd1) begin
                        lives_d = lives_q - 3'd1;
                        state_d = PLAYER_HIT;
                        timer_d = '0;
                    end else begin
                        lives_d = 3'd0;
                        state_d = OVER;
                    end
                end
            end
            PLAYER_HIT: begin
                if (startOfFrame) begin
                    if (timer_q == 16'(RESPAWN_FRAMES - 1)) state_d = PLAYING;
                    else timer_d = timer_q + 16'd1;
                end
            end
            CLEAR: begin
                if (startOfFrame) begin
                    if (timer_q != 16'(CLEAR_FRAMES - 1)) begin
                        timer_d = timer_q + 16'd1;
                    end else if (stage_num_q == game_stage_t'(LAST_STAGE)) begin
                        state_d = WON;
                    end else begin
                        stage_num_d    = stage_num_q + 3'd1;
                        state_d        = INTRO;
                        timer_d        = '0;
                        stage_resetN_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        // Flags follow the next state so they are valid from the first clk of each state.
        stage_enable_d = (state_d == PLAYING);
        show_banner_d  = (state_d == INTRO);
        game_over_d    = (state_d == OVER);
        game_won_d     = (state_d == WON);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= IDLE;
            stage_num_q    <= '0;
            lives_q        <= 3'(INITIAL_LIVES);
            score_q        <= '0;
            timer_q        <= '0;
            stage_enable_q <= 1'b0;
            stage_resetN_q <= 1'b1;
            show_banner_q  <= 1'b0;
            game_over_q    <= 1'b0;
            game_won_q     <= 1'b0;
`ifdef GAME_STAGE_BONUS_EN
            bonus_pulse_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            stage_num_q    <= stage_num_d;
            lives_q        <= lives_d;
            score_q        <= score_d;
            timer_q        <= timer_d;
            stage_enable_q <= stage_enable_d;
            stage_resetN_q <= stage_resetN_d;
            show_banner_q  <= show_banner_d;
            game_over_q    <= game_over_d;
            game_won_q     <= game_won_d;
`ifdef GAME_STAGE_BONUS_EN
            bonus_pulse_q  <= clear_now;
`endif
        end
    end

    assign stage_num    = stage_num_q;
    assign stage_enable = stage_enable_q;
    assign stage_resetN = stage_resetN_q;
    assign show_banner  = show_banner_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign game_over    = game_over_q;
    assign game_won     = game_won_q;
`ifdef GAME_STAGE_BONUS_EN
    assign bonus_pulse  = bonus_pulse_q;
`endif

endmodule

// File: tb/tb_game_stage_controller.sv
// Scoreboard bench for game_stage_controller: a frame/score reference model predicts every
// output change and a monitor compares each DUT change. GAME_STAGE_BONUS_EN adds bonus checks.
module tb_game_stage_controller;

    localparam int INTRO_F     = 120;
    localparam int CLEAR_F     = 90;
    localparam int RESPAWN_F   = 60;
    localparam int START_LIVES = 3;
    localparam int FINAL_STAGE = 4;
    localparam int BOSS_LEVEL  = 3;
`ifdef GAME_STAGE_BONUS_EN
    localparam int OUT_W = 28;
`else
    localparam int OUT_W = 27;
`endif

    typedef enum {P_MENU, P_BANNER, P_ACTION, P_FROZEN, P_CLEARED, P_LOST, P_VICTORY} phase_t;
    typedef struct {
        int               cyc;
        logic [OUT_W-1:0] vec;
    } expect_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        start_pulse = 1'b0;
    logic        all_monsters_dead = 1'b0;
    logic        monster_died_pulse = 1'b0;
    logic        boss_dead = 1'b0;
    logic        player_died_pulse = 1'b0;
    logic [2:0]  stage_num;
    logic        stage_enable;
    logic        stage_resetN;
    logic        show_banner;
    logic [2:0]  lives;
    logic [15:0] score;
    logic        game_over;
    logic        game_won;
    logic [OUT_W-1:0] dut_vec;

    expect_t sb[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    bit      mon_en = 1'b0;
    int      sof_gap = 3;

    phase_t           m_phase;
    int               m_stage, m_lives, m_score, m_frames;
    bit               m_reinit, m_bonus;
    logic [OUT_W-1:0] m_last;

`ifdef GAME_STAGE_BONUS_EN
    logic bonus_pulse;
    game_stage_controller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_pulse(start_pulse),
        .all_monsters_dead(all_monsters_dead), .monster_died_pulse(monster_died_pulse),
        .boss_dead(boss_dead), .player_died_pulse(player_died_pulse), .stage_num(stage_num),
        .stage_enable(stage_enable), .stage_resetN(stage_resetN), .show_banner(show_banner),
        .lives(lives), .score(score), .game_over(game_over), .game_won(game_won),
        .bonus_pulse(bonus_pulse));
    assign dut_vec = {stage_num, stage_enable, stage_resetN, show_banner, lives, score,
                      game_over, game_won, bonus_pulse};
`else
    game_stage_controller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_pulse(start_pulse),
        .all_monsters_dead(all_monsters_dead), .monster_died_pulse(monster_died_pulse),
        .boss_dead(boss_dead), .player_died_pulse(player_died_pulse), .stage_num(stage_num),
        .stage_enable(stage_enable), .stage_resetN(stage_resetN), .show_banner(show_banner),
        .lives(lives), .score(score), .game_over(game_over), .game_won(game_won));
    assign dut_vec = {stage_num, stage_enable, stage_resetN, show_banner, lives, score,
                      game_over, game_won};
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] toBcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [OUT_W-1:0] modelVec();
        logic [26:0] base;
        base = {3'(m_stage), m_phase == P_ACTION, !m_reinit, m_phase == P_BANNER, 3'(m_lives),
                toBcd(m_score), m_phase == P_LOST, m_phase == P_VICTORY};
`ifdef GAME_STAGE_BONUS_EN
        return {base, m_bonus};
`else
        return base;
`endif
    endfunction

    task automatic modelReset();
        m_phase  = P_MENU;
        m_stage  = 0;
        m_lives  = START_LIVES;
        m_score  = 0;
        m_frames = 0;
        m_reinit = 1'b0;
        m_bonus  = 1'b0;
        m_last   = modelVec();
    endtask

    task automatic enterBanner();
        m_phase  = P_BANNER;
        m_frames = INTRO_F;
        m_reinit = 1'b1;
    endtask

    // One clock of game rules: frames count down, score is a plain integer capped at 9999.
    task automatic modelStep(input bit start, input bit sof, input bit amd, input bit mdp,
                             input bit bd, input bit pdp);
        bit done;
        int gain;
        m_reinit = 1'b0;
        m_bonus  = 1'b0;
        case (m_phase)
            P_MENU, P_LOST, P_VICTORY: begin
                if (start) begin
                    m_stage = 1;
                    m_lives = START_LIVES;
                    m_score = 0;
                    enterBanner();
                end
            end
            P_BANNER, P_FROZEN: begin
                if (sof) begin
                    m_frames--;
                    if (m_frames == 0) m_phase = P_ACTION;
                end
            end
            P_ACTION: begin
                done = (m_stage == BOSS_LEVEL) ? bd : amd;
                gain = int'(mdp);
                if (done) begin
`ifdef GAME_STAGE_BONUS_EN
                    gain    = gain + 10 * m_lives;
                    m_bonus = 1'b1;
`endif
                    m_phase  = P_CLEARED;
                    m_frames = CLEAR_F;
                end else if (pdp) begin
                    m_lives--;
                    if (m_lives == 0) begin
                        m_phase = P_LOST;
                    end else begin
                        m_phase  = P_FROZEN;
                        m_frames = RESPAWN_F;
                    end
                end
                m_score = (m_score + gain > 9999) ? 9999 : m_score + gain;
            end
            P_CLEARED: begin
                if (sof) begin
                    m_frames--;
                    if (m_frames == 0) begin
                        if (m_stage == FINAL_STAGE) begin
                            m_phase = P_VICTORY;
                        end else begin
                            m_stage++;
                            enterBanner();
                        end
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [OUT_W-1:0] got,
                               input logic [OUT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, required %h", name, cyc, got, exp);
        end
    endtask

    // Drives one clock of inputs and queues the model's prediction if any output changes.
    task automatic applyStimulus(input bit start, input bit amd, input bit mdp, input bit bd,
                                 input bit pdp);
        bit      sof;
        expect_t e;
        @(negedge clk);
        sof_gap--;
        sof = (sof_gap == 0);
        if (sof) sof_gap = $urandom_range(2, 4);
        start_pulse        = start;
        startOfFrame       = sof;
        all_monsters_dead  = amd;
        monster_died_pulse = mdp;
        boss_dead          = bd;
        player_died_pulse  = pdp;
        modelStep(start, sof, amd, mdp, bd, pdp);
        e.vec = modelVec();
        if (e.vec !== m_last) begin
            e.cyc  = cyc + 1;
            m_last = e.vec;
            sb.push_back(e);
        end
    endtask

    task automatic noiseCycle();
        bit st;
        st = !(m_phase inside {P_MENU, P_LOST, P_VICTORY}) && ($urandom_range(0, 15) == 0);
        applyStimulus(st, 1'b0, $urandom_range(0, 3) == 0, 1'b0, 1'b0);
    endtask

    task automatic randomCycle();
        applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 29) == 0);
    endtask

    task automatic waitPhase(input phase_t target, input int budget);
        int n = 0;
        while (m_phase != target && n < budget) begin
            noiseCycle();
            n++;
        end
        if (m_phase != target) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_timeout: phase %0d after %0d cycles, required %0d",
                     m_phase, n, target);
        end
    endtask

    task automatic resetGame();
        expect_t e;
        @(negedge clk);
        start_pulse        = 1'b0;
        startOfFrame       = 1'b0;
        all_monsters_dead  = 1'b0;
        monster_died_pulse = 1'b0;
        boss_dead          = 1'b0;
        player_died_pulse  = 1'b0;
        #1 resetN = 1'b0;
        e.vec = m_last;
        modelReset();
        #1 checkOutput("async_reset", dut_vec, m_last);
        if (e.vec !== m_last) begin
            e.cyc = cyc + 1;
            e.vec = m_last;
            sb.push_back(e);
        end
        repeat (3) @(negedge clk);
        #1 resetN = 1'b1;
    endtask

    // Monitor: every change on the DUT outputs must match the next queued prediction and its cycle.
    initial begin
        logic [OUT_W-1:0] prev, cur;
        expect_t          e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = dut_vec;
            if (mon_en && cur !== prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_change at cycle %0d: got %h, required %h",
                             cyc, cur, prev);
                end else begin
                    e = sb.pop_front();
                    checkOutput("outputs", cur, e.vec);
                    checks++;
                    if (e.cyc != cyc) begin
                        errors++;
                        $display("[TB] FAIL change_timing: change seen at cycle %0d, required cycle %0d",
                                 cyc, e.cyc);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_state", dut_vec, m_last);
        #1 resetN = 1'b1;
        mon_en = 1'b1;
        $display("[TB] start stage 1");
        repeat (4) applyStimulus(1'b0, 1'b0, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitPhase(P_ACTION, 3000);

        $display("[TB] score carry and saturation");
        for (int i = 0; i < 10010; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] simultaneous clear and death");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        waitPhase(P_ACTION, 3000);
        repeat (20) noiseCycle();

        $display("[TB] mid-play reset at stage 2");
        resetGame();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitPhase(P_ACTION, 3000);
        for (int s = 1; s < 3; s++) begin
            applyStimulus(1'b0, 1'b1, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
            waitPhase(P_ACTION, 3000);
        end

        $display("[TB] boss stage");
        repeat (40) applyStimulus(1'b0, 1'b1, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        waitPhase(P_ACTION, 3000);

        $display("[TB] lives");
        for (int d = 0; d < 3; d++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (d < 2) waitPhase(P_ACTION, 3000);
        end
        repeat (10) noiseCycle();

        $display("[TB] full game to win");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitPhase(P_ACTION, 3000);
        for (int s = 1; s <= FINAL_STAGE; s++) begin
            applyStimulus(1'b0, 1'b1, $urandom_range(0, 1) == 1, 1'b1, 1'b0);
            waitPhase((s == FINAL_STAGE) ? P_VICTORY : P_ACTION, 3000);
        end
        repeat (5) noiseCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] random soak");
        for (int i = 0; i < 4000; i++) randomCycle();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_expectations: got %0d unmatched, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_stage_controller.md
Name: game_stage_controller

Overview:
- Top-level game-flow FSM that sits directly downstream of the monsters block.
- Consumes all_monsters_dead, monster_died_pulse, boss and player events; produces stage_num, the monsters' enable, and a per-stage re-init reset.
- Keeps lives and a 4-digit BCD score for the HUD.
- Stage 0 is the menu, stages 1–4 are played, and stage 3 is the boss stage with zero monsters.

Parameters:
- INTRO_FRAMES, 120, frames the stage banner is shown before play starts.
- CLEAR_FRAMES, 90, frames held after a stage is cleared.
- RESPAWN_FRAMES, 60, frames frozen after the player is hit.
- INITIAL_LIVES, 3, lives at game start (1..7).
- LAST_STAGE, 4, final playable stage; clearing it wins the game.
- BOSS_STAGE, 3, stage whose completion is boss_dead instead of all_monsters_dead.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-clk pulse per video frame
- start_pulse  in  1  debounced start-key pulse
- all_monsters_dead  in  1  level, from monsters block
- monster_died_pulse  in  1  one-clk pulse per monster killed
- boss_dead  in  1  level, boss destroyed
- player_died_pulse  in  1  one-clk pulse, player hit
- stage_num  out  3 (game_stage)  current stage 0..4
- stage_enable  out  1  gameplay objects may move/shoot
- stage_resetN  out  1  active-low one-clk re-init pulse for stage objects
- show_banner  out  1  HUD draws stage banner
- lives  out  3  remaining lives
- score  out  16  4 BCD digits, [15:12] most significant
- game_over  out  1  level, lost
- game_won  out  1  level, won

Behaviour:
- Reset values: state IDLE, stage_num 0, stage_enable 0, stage_resetN 1, show_banner 0, lives INITIAL_LIVES, score 0, game_over 0, game_won 0.
- FSM states: IDLE, INTRO, PLAYING, PLAYER_HIT, CLEAR, OVER, WON. All outputs are registered.
- IDLE:
  - On start_pulse: stage_num←1, lives←INITIAL_LIVES, score←0, go to INTRO.
- Entering INTRO:
  - stage_resetN is driven 0 for exactly the first clk in INTRO, then 1.
  - Frame timer loads 0.
- INTRO:
  - show_banner=1, stage_enable=0.
  - Timer increments on startOfFrame.
  - When timer == INTRO_FRAMES-1 and startOfFrame is high: go to PLAYING.
- PLAYING:
  - stage_enable=1.
  - Completion condition is (stage_num==BOSS_STAGE ? boss_dead : all_monsters_dead).
  - If complete: go to CLEAR. Completion takes priority over a same-cycle player_died_pulse.
  - Else if player_died_pulse and lives>1: lives−1, go to PLAYER_HIT.
  - Else if player_died_pulse and lives==1: lives←0, go to OVER.
- PLAYER_HIT:
  - stage_enable=0.
  - After RESPAWN_FRAMES frames: return to PLAYING. No stage re-init.
- CLEAR:
  - stage_enable=0.
  - After CLEAR_FRAMES frames:
    - if stage_num==LAST_STAGE, go to WON;
    - else stage_num+1, go to INTRO.
- OVER: game_over=1, WON: game_won=1.
  - Both hold until start_pulse, which clears the flag and behaves as the IDLE start.
- Score:
  - monster_died_pulse while in PLAYING adds 1 in BCD with per-digit carry.
  - The score saturates at 9999.
  - Pulses in any other state are ignored.
- start_pulse outside IDLE/OVER/WON is ignored.
- Asynchronous reset mid-game returns immediately to the reset values.

Optional Feature:
- Macro: GAME_STAGE_BONUS_EN.
- Defined:
  - On the transition PLAYING→CLEAR, add 10×lives points to the score, BCD, saturating at 9999.
  - The bonus is applied in the transition cycle. A same-cycle monster_died_pulse also counts, so the total added is 10×lives+1.
  - A one-clk bonus_pulse output is added.
- Undefined: no bonus and no bonus_pulse port.

Decomposition:
- Shared package:
  - the game_stage typedef;
  - the FSM state enum;
  - the BCD score typedef (4×4 bits);
  - default timing constants.
- One natural sub-module: bcd_score_adder. It is combinational, adding an 8-bit binary increment (1 or 10×lives) to 4 BCD digits with saturation. The controller registers its result.

Test Plan:
- Start stage 1: reset, start_pulse → stage_resetN low exactly 1 clk, show_banner 1 for 120 frames, then stage_enable 1 and stage_num 1.
- Score carry: PLAYING with score 0099, one monster_died_pulse → 0100. With score 9999, another pulse → stays 9999.
- Boss stage completion: at stage 3, all_monsters_dead=1 with boss_dead=0 → stays PLAYING. Raise boss_dead → CLEAR, and after 90 frames stage_num=4 with INTRO.
- Lives: three player_died_pulses in PLAYING, separated by 60-frame respawns → lives 2, 1, then 0 with game_over=1 and stage_enable 0.
- Simultaneous events: all_monsters_dead and player_died_pulse in the same clk → CLEAR, lives unchanged. Clearing stage 4 → game_won=1. A following start_pulse → stage_num 1, score 0000, lives 3.
- Mid-play reset: resetN low during PLAYING at stage 2 → all outputs return to their reset values asynchronously. With GAME_STAGE_BONUS_EN, clearing with 2 lives from score 0005 → 0025 and one bonus_pulse.
